hls_deadlock_persist_monitor: RTL and testbench
===============================================

// Module: hls_deadlock_persist_monitor
// PURPOSE
//  Parametrised successor of the per-instance HLS deadlock monitors. Watches N AXIS-stall
//  and M sub-instance block flags, filters transient stalls with a persistence window,
//  records the first offending channel and counts cycles spent blocked.
//  Its output feeds the parent monitor's block tree or the top-level deadlock report.
// PARAMETERS
//  NUM_CH      7   AXIS channels watched (>=1)
//  NUM_SUB     1   sub-instance block inputs (>=1)
//  PERSIST     16  consecutive raw-stall cycles needed to declare block (>=1)
//  CNT_W       16  width of the blocked-cycle counter
//  IDX_W       4   width of the offender index; must satisfy 2**IDX_W >= NUM_CH+NUM_SUB
// PORTS
//  clock            in   1        single clock; all logic on its rising edge
//  reset            in   1        synchronous, active-low reset
//  axis_block_sigs  in   NUM_CH   per-channel AXIS stall flag
//  inst_idle_sigs   in   NUM_CH   per-channel owning-instance idle flag
//  inst_block_sigs  in   NUM_SUB  block outputs of child monitors
//  ch_mask          in   NUM_CH   1 = channel participates; quasi-static configuration
//  clear            in   1        one-cycle pulse: return to IDLE, zero the counters
//  block            out  1        deadlock declared
//  block_idx        out  IDX_W    offender index: 0..NUM_CH-1 = channel, NUM_CH+j = sub j
//  block_idx_vld    out  1        block_idx holds a captured offender
//  block_cycles     out  CNT_W    cycles spent in BLOCKED; saturates at all-ones
// BEHAVIOUR
//  raw_ch[i] = axis_block_sigs[i] & ch_mask[i] & ~inst_idle_sigs[i]; raw_sub = inst_block_sigs.
//  raw = |raw_ch | |raw_sub. Combinational; no input registering.
//  Reset (reset==0 at clock edge): state=IDLE; persist_cnt=0; block=0; block_idx=0;
//   block_idx_vld=0; block_cycles=0. Reset overrides clear and every other input.
//  FSM (IDLE, SUSPECT, BLOCKED), evaluated every cycle when reset==1:
//   IDLE:    raw & PERSIST==1 -> BLOCKED. raw & PERSIST>1 -> SUSPECT, persist_cnt=1.
//   SUSPECT: !raw -> IDLE, persist_cnt=0. raw & persist_cnt==PERSIST-1 -> BLOCKED.
//            raw otherwise -> persist_cnt+1.
//   BLOCKED: !raw -> IDLE; persist_cnt=0; block_cycles is held. raw -> stay.
//  block is registered: block==1 exactly while state==BLOCKED. Assertion latency is
//   PERSIST cycles after the first raw cycle; PERSIST=1 gives one-cycle latency.
//  Offender capture: on the IDLE/SUSPECT->BLOCKED transition, block_idx takes the
//   lowest set index of {raw_sub, raw_ch}, channels first; block_idx_vld is set to 1.
//   Index and vld hold until clear or reset. Re-entering BLOCKED recaptures.
//  block_cycles: reset to 0 on entry to BLOCKED; increments every cycle in BLOCKED;
//   saturates at 2**CNT_W-1 and never wraps.
//  clear==1: next state=IDLE; persist_cnt=0; block_cycles=0; block_idx_vld=0.
//   clear takes priority over raw in the same cycle; raw next cycle restarts SUSPECT.
//  Changing ch_mask mid-SUSPECT changes raw immediately; no other side effects.
//  All raw sources dropping in the same cycle that the threshold is reached -> IDLE, no block.
// CONFIGURATION
//  HLS_DEADLOCK_STICKY_EN defined: BLOCKED is sticky. !raw does not leave BLOCKED;
//   block stays 1 until clear or reset. block_cycles keeps counting while raw==0.
//  HLS_DEADLOCK_STICKY_EN undefined: transitions exactly as listed under BEHAVIOUR.
// TESTING (NUM_CH=7, NUM_SUB=1, PERSIST=4, CNT_W=4)
//  1. axis_block_sigs[2]=1 for 3 cycles, then 0 (mask all 1, idle 0) -> block never 1;
//     state returns to IDLE.
//  2. axis_block_sigs[2]=1 and [5]=1 held -> block=1 on the 4th edge; block_idx=2;
//     vld=1; block_cycles counts up to 15 and holds there.
//  3. Stall on ch3 with inst_idle_sigs[3]=1, or with ch_mask[3]=0 -> block stays 0.
//  4. inst_block_sigs[0]=1 held -> block_idx=7 after 4 cycles;
//     clear pulse -> block=0 the next cycle, vld=0, block_cycles=0, SUSPECT restarts.
//  5. In BLOCKED, drop all stalls -> block=0 next cycle with macro undefined;
//     block stays 1 with macro defined until clear.
//  6. Drive reset=0 for one edge mid-SUSPECT and mid-BLOCKED -> all outputs return to 0
//     at that edge.

Source files
------------

// File: rtl/hls_deadlock_persist_monitor.sv
// Persistence-filtered deadlock monitor over NUM_CH AXIS stall flags and NUM_SUB child block flags.
// Optional macro HLS_DEADLOCK_STICKY_EN: BLOCKED is left only by clear or reset.
module hls_deadlock_persist_monitor #(
  parameter int unsigned NUM_CH  = 7,
  parameter int unsigned NUM_SUB = 1,
  parameter int unsigned PERSIST = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  axis_block_sigs,
  input  logic [NUM_CH-1:0]  inst_idle_sigs,
  input  logic [NUM_SUB-1:0] inst_block_sigs,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic               clear,
  output logic               block,
  output logic [IDX_W-1:0]   block_idx,
  output logic               block_idx_vld,
  output logic [CNT_W-1:0]   block_cycles
);

  localparam int unsigned PC_W = (PERSIST > 1) ? $clog2(PERSIST) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERSIST - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  persist_cnt_q, persist_cnt_d;
  logic             block_q, block_d;
  logic [IDX_W-1:0] block_idx_q, block_idx_d;
  logic             block_idx_vld_q, block_idx_vld_d;
  logic [CNT_W-1:0] block_cycles_q, block_cycles_d;

  logic [NUM_CH-1:0]  raw_ch;
  logic [NUM_SUB-1:0] raw_sub;
  logic               raw;
  logic [IDX_W-1:0]   off_idx;
  logic [CNT_W-1:0]   cycles_inc;

  assign raw_ch  = axis_block_sigs & ch_mask & ~inst_idle_sigs;
  assign raw_sub = inst_block_sigs;
  assign raw     = (|raw_ch) | (|raw_sub);

  // Lowest active source wins; channels outrank sub-instances.
  always_comb begin
    off_idx = '0;
    for (int j = int'(NUM_SUB) - 1; j >= 0; j--) begin
      if (raw_sub[j]) off_idx = IDX_W'(int'(NUM_CH) + j);
    end
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (raw_ch[i]) off_idx = IDX_W'(i);
    end
  end

  assign cycles_inc = (block_cycles_q == '1) ? block_cycles_q : block_cycles_q + CNT_W'(1);

  always_comb begin
    state_d         = state_q;
    persist_cnt_d   = persist_cnt_q;
    block_idx_d     = block_idx_q;
    block_idx_vld_d = block_idx_vld_q;
    block_cycles_d  = block_cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (raw) begin
          if (PERSIST == 1) begin
            state_d         = ST_BLOCKED;
            persist_cnt_d   = '0;
            block_idx_d     = off_idx;
            block_idx_vld_d = 1'b1;
            block_cycles_d  = '0;
          end else begin
            state_d       = ST_SUSPECT;
            persist_cnt_d = PC_W'(1);
          end
        end
      end
      ST_SUSPECT: begin
        if (!raw) begin
          state_d       = ST_IDLE;
          persist_cnt_d = '0;
        end else if (persist_cnt_q == PC_LAST) begin
          state_d         = ST_BLOCKED;
          persist_cnt_d   = '0;
          block_idx_d     = off_idx;
          block_idx_vld_d = 1'b1;
          block_cycles_d  = '0;
        end else begin
          persist_cnt_d = persist_cnt_q + PC_W'(1);
        end
      end
      ST_BLOCKED: begin
`ifdef HLS_DEADLOCK_STICKY_EN
        block_cycles_d = cycles_inc;
`else
        if (!raw) begin
          state_d       = ST_IDLE;
          persist_cnt_d = '0;
        end else begin
          block_cycles_d = cycles_inc;
        end
`endif
      end
      default: begin
        state_d       = ST_IDLE;
        persist_cnt_d = '0;
      end
    endcase

    // clear overrides any transition requested this cycle
    if (clear) begin
      state_d         = ST_IDLE;
      persist_cnt_d   = '0;
      block_cycles_d  = '0;
      block_idx_vld_d = 1'b0;
    end

    block_d = (state_d == ST_BLOCKED);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      persist_cnt_q   <= '0;
      block_q         <= 1'b0;
      block_idx_q     <= '0;
      block_idx_vld_q <= 1'b0;
      block_cycles_q  <= '0;
    end else begin
      state_q         <= state_d;
      persist_cnt_q   <= persist_cnt_d;
      block_q         <= block_d;
      block_idx_q     <= block_idx_d;
      block_idx_vld_q <= block_idx_vld_d;
      block_cycles_q  <= block_cycles_d;
    end
  end

  assign block         = block_q;
  assign block_idx     = block_idx_q;
  assign block_idx_vld = block_idx_vld_q;
  assign block_cycles  = block_cycles_q;

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Directed vector bench for hls_deadlock_persist_monitor (NUM_CH=7, NUM_SUB=1, PERSIST=4, CNT_W=4).
module tb_hls_deadlock_persist_monitor;

  localparam int unsigned NUM_CH  = 7;
  localparam int unsigned NUM_SUB = 1;
  localparam int unsigned PERSIST = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 4;

`ifdef HLS_DEADLOCK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic              rst;
    logic              clr;
    logic [6:0]        axis;
    logic [6:0]        idle;
    logic [6:0]        mask;
    logic [0:0]        sub;
    logic              e_block;
    logic [3:0]        e_idx;
    logic              e_vld;
    logic [3:0]        e_cyc;
  } vec_t;

  logic               clock;
  logic               reset;
  logic [NUM_CH-1:0]  axis_block_sigs;
  logic [NUM_CH-1:0]  inst_idle_sigs;
  logic [NUM_SUB-1:0] inst_block_sigs;
  logic [NUM_CH-1:0]  ch_mask;
  logic               clear;
  logic               block;
  logic [IDX_W-1:0]   block_idx;
  logic               block_idx_vld;
  logic [CNT_W-1:0]   block_cycles;

  int total;
  int bad;
  vec_t vq[$];

  hls_deadlock_persist_monitor #(
    .NUM_CH (NUM_CH),
    .NUM_SUB(NUM_SUB),
    .PERSIST(PERSIST),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs (inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .ch_mask        (ch_mask),
    .clear          (clear),
    .block          (block),
    .block_idx      (block_idx),
    .block_idx_vld  (block_idx_vld),
    .block_cycles   (block_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic clr, input logic [6:0] axis,
                              input logic [6:0] idle, input logic [6:0] mask, input logic sub,
                              input logic eb, input logic [3:0] ei, input logic ev,
                              input logic [3:0] ec);
    vec_t v;
    v.rst = rst; v.clr = clr; v.axis = axis; v.idle = idle; v.mask = mask; v.sub = sub;
    v.e_block = eb; v.e_idx = ei; v.e_vld = ev; v.e_cyc = ec;
    return v;
  endfunction

  task automatic check(input string tag, input logic eb, input logic [3:0] ei,
                       input logic ev, input logic [3:0] ec);
    total = total + 4;
    if (block !== eb) begin
      bad++;
      $display("FAIL %s block: got %0b want %0b", tag, block, eb);
    end
    if (block_idx !== ei) begin
      bad++;
      $display("FAIL %s block_idx: got %0d want %0d", tag, block_idx, ei);
    end
    if (block_idx_vld !== ev) begin
      bad++;
      $display("FAIL %s block_idx_vld: got %0b want %0b", tag, block_idx_vld, ev);
    end
    if (block_cycles !== ec) begin
      bad++;
      $display("FAIL %s block_cycles: got %0d want %0d", tag, block_cycles, ec);
    end
  endtask

  // Drive inputs on the falling edge, sample one time unit past the rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    reset           = v.rst;
    clear           = v.clr;
    axis_block_sigs = v.axis;
    inst_idle_sigs  = v.idle;
    ch_mask         = v.mask;
    inst_block_sigs = v.sub;
    @(posedge clock);
    #1;
    check(tag, v.e_block, v.e_idx, v.e_vld, v.e_cyc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; clear = 1'b0;
    axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0; ch_mask = '1;

    // rows 0..9: reset, transient stall, persistent dual-channel stall
    vq.push_back(mk(0,0,7'h00,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h04,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h04,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h04,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h24,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h24,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h24,7'h00,7'h7F,0, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h24,7'h00,7'h7F,0, 1,4'd2,1,4'd0));
    // row 10..: stall drop, clear, idle/mask filtering, sub offender, resets, corners
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,0, STICKY,4'd2,1,4'd15));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,0, STICKY,4'd2,1,4'd15));
    vq.push_back(mk(1,1,7'h00,7'h00,7'h7F,0, 0,4'd2,0,4'd0));
    for (int k = 0; k < 4; k++) vq.push_back(mk(1,0,7'h08,7'h08,7'h7F,0, 0,4'd2,0,4'd0));
    for (int k = 0; k < 4; k++) vq.push_back(mk(1,0,7'h08,7'h00,7'h77,0, 0,4'd2,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd2,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd2,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd2,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 1,4'd7,1,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 1,4'd7,1,4'd1));
    vq.push_back(mk(1,1,7'h00,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 1,4'd7,1,4'd0));
    vq.push_back(mk(0,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(0,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 0,4'd0,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,1, 1,4'd7,1,4'd0));
    vq.push_back(mk(1,1,7'h00,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h01,7'h00,7'h7F,0, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h01,7'h00,7'h7F,0, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h01,7'h00,7'h7F,0, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h00,7'h00,7'h7F,0, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h40,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h40,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h40,7'h00,7'h7F,1, 0,4'd7,0,4'd0));
    vq.push_back(mk(1,0,7'h40,7'h00,7'h7F,1, 1,4'd6,1,4'd0));
    vq.push_back(mk(1,1,7'h00,7'h00,7'h7F,0, 0,4'd6,0,4'd0));
    vq.push_back(mk(1,0,7'h08,7'h00,7'h7F,0, 0,4'd6,0,4'd0));
    vq.push_back(mk(1,0,7'h08,7'h00,7'h77,0, 0,4'd6,0,4'd0));
    vq.push_back(mk(1,0,7'h08,7'h00,7'h7F,0, 0,4'd6,0,4'd0));
    vq.push_back(mk(1,0,7'h08,7'h00,7'h7F,0, 0,4'd6,0,4'd0));
    vq.push_back(mk(1,0,7'h08,7'h00,7'h7F,0, 0,4'd6,0,4'd0));
    vq.push_back(mk(1,0,7'h08,7'h00,7'h7F,0, 1,4'd3,1,4'd0));

    for (int i = 0; i < 10; i++) apply(vq[i], $sformatf("vec%0d", i));

    // Counter saturation: hold the stall for 20 more cycles.
    for (int k = 1; k <= 20; k++) begin
      vec_t v;
      v = mk(1,0,7'h24,7'h00,7'h7F,0, 1,4'd2,1, (k > 15) ? 4'd15 : 4'(k));
      apply(v, $sformatf("sat%0d", k));
    end

    for (int i = 10; i < vq.size(); i++) apply(vq[i], $sformatf("vec%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
